// File: rtl/natural_order_buffer.sv
// Reorders a bit-reversed complex stream into natural order using two ping-pong banks.
// Define NATURAL_ORDER_BUFFER_FRAME_CNT_EN to add the 8-bit frame_count output port.
module natural_order_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] data_in_r,
  input  logic [DATA_WIDTH-1:0] data_in_i,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] data_out_r,
  output logic [DATA_WIDTH-1:0] data_out_i,
  output logic                  out_last
`ifdef NATURAL_ORDER_BUFFER_FRAME_CNT_EN
  ,
  output logic [7:0]            frame_count
`endif
);

  localparam int N = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(N - 1);

  function automatic logic [ADDR_WIDTH-1:0] bitRev(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] r;
    r = '0;
    for (int b = 0; b < ADDR_WIDTH; b++) begin
      r[b] = a[ADDR_WIDTH-1-b];
    end
    return r;
  endfunction

  logic [DATA_WIDTH-1:0] memR_q [2][N];
  logic [DATA_WIDTH-1:0] memI_q [2][N];

  logic [1:0]            full_q,     full_d;
  logic                  wrBank_q,   wrBank_d;
  logic                  rdBank_q,   rdBank_d;
  logic [ADDR_WIDTH-1:0] wrCnt_q,    wrCnt_d;
  logic [ADDR_WIDTH-1:0] rdCnt_q,    rdCnt_d;
  logic                  outValid_q, outValid_d;
  logic                  outLast_q,  outLast_d;
  logic [DATA_WIDTH-1:0] outR_q,     outR_d;
  logic [DATA_WIDTH-1:0] outI_q,     outI_d;

  logic wrAccept;
  logic rdLoad;
  logic outTake;

  assign in_ready   = ~full_q[wrBank_q];
  assign out_valid  = outValid_q;
  assign out_last   = outLast_q;
  assign data_out_r = outR_q;
  assign data_out_i = outI_q;

  assign wrAccept = in_valid & in_ready;
  assign outTake  = outValid_q & out_ready;
  assign rdLoad   = full_q[rdBank_q] & (~outValid_q | out_ready);

  // Write and read sides never touch the same full flag in one cycle:
  // a bank being written is empty, a bank being read is full.
  always_comb begin
    full_d     = full_q;
    wrBank_d   = wrBank_q;
    rdBank_d   = rdBank_q;
    wrCnt_d    = wrCnt_q;
    rdCnt_d    = rdCnt_q;
    outValid_d = outValid_q;
    outLast_d  = outLast_q;
    outR_d     = outR_q;
    outI_d     = outI_q;

    if (wrAccept) begin
      wrCnt_d = wrCnt_q + 1'b1;
      if (wrCnt_q == LAST_IDX) begin
        full_d[wrBank_q] = 1'b1;
        wrBank_d         = ~wrBank_q;
        wrCnt_d          = '0;
      end
    end

    if (rdLoad) begin
      outValid_d = 1'b1;
      outR_d     = memR_q[rdBank_q][rdCnt_q];
      outI_d     = memI_q[rdBank_q][rdCnt_q];
      outLast_d  = (rdCnt_q == LAST_IDX);
      rdCnt_d    = rdCnt_q + 1'b1;
      if (rdCnt_q == LAST_IDX) begin
        full_d[rdBank_q] = 1'b0;
        rdBank_d         = ~rdBank_q;
        rdCnt_d          = '0;
      end
    end else if (outTake) begin
      outValid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q     <= '0;
      wrBank_q   <= 1'b0;
      rdBank_q   <= 1'b0;
      wrCnt_q    <= '0;
      rdCnt_q    <= '0;
      outValid_q <= 1'b0;
      outLast_q  <= 1'b0;
      outR_q     <= '0;
      outI_q     <= '0;
    end else begin
      full_q     <= full_d;
      wrBank_q   <= wrBank_d;
      rdBank_q   <= rdBank_d;
      wrCnt_q    <= wrCnt_d;
      rdCnt_q    <= rdCnt_d;
      outValid_q <= outValid_d;
      outLast_q  <= outLast_d;
      outR_q     <= outR_d;
      outI_q     <= outI_d;
    end
  end

  // Sample storage is deliberately not reset; full flags gate every read.
  always_ff @(posedge clk) begin
    if (!rst && wrAccept) begin
      memR_q[wrBank_q][bitRev(wrCnt_q)] <= data_in_r;
      memI_q[wrBank_q][bitRev(wrCnt_q)] <= data_in_i;
    end
  end

`ifdef NATURAL_ORDER_BUFFER_FRAME_CNT_EN
  logic [7:0] frameCnt_q, frameCnt_d;

  always_comb begin
    frameCnt_d = frameCnt_q;
    if (outTake && outLast_q) begin
      frameCnt_d = frameCnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frameCnt_q <= 8'd0;
    end else begin
      frameCnt_q <= frameCnt_d;
    end
  end

  assign frame_count = frameCnt_q;
`endif

endmodule

// File: tb/tb_natural_order_buffer.sv
// Scoreboard bench for natural_order_buffer: a monitor compares every output
// transfer against frames reordered by a bench-side index-reversal model.
module tb_natural_order_buffer;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int N  = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] data_in_r;
  logic [DW-1:0] data_in_i;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] data_out_r;
  logic [DW-1:0] data_out_i;
  logic          out_last;
`ifdef NATURAL_ORDER_BUFFER_FRAME_CNT_EN
  logic [7:0]    frame_count;
`endif

  natural_order_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .data_in_r  (data_in_r),
    .data_in_i  (data_in_i),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .data_out_r (data_out_r),
    .data_out_i (data_out_i),
    .out_last   (out_last)
`ifdef NATURAL_ORDER_BUFFER_FRAME_CNT_EN
    ,
    .frame_count(frame_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] r;
    logic [DW-1:0] i;
    logic          last;
  } sample_t;

  int errors = 0;
  int checks = 0;
  int cycle = 0;
  int inAccepted = 0;
  int outCount = 0;
  int framesOut = 0;
  int readyMode = 0;
  int outCycle[$];
  sample_t sbQ[$];
  sample_t expS;
  logic [DW-1:0] frameR[N];
  logic [DW-1:0] frameI[N];
  int wrK = 0;
  logic prevHeld = 1'b0;
  logic [DW-1:0] heldR;
  logic [DW-1:0] heldI;
  logic heldLast;

  always @(posedge clk) cycle++;

  // Reference reordering: natural output n carries input sample whose index is n read backwards in binary.
  function automatic int revIdx(input int n);
    int r = 0;
    int v = n;
    for (int b = 0; b < AW; b++) begin
      r = r * 2 + (v % 2);
      v = v / 2;
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cycle);
    end
  endtask

  // out_ready policy: 0 = always high, 1 = held low, 2 = random.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (readyMode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'b0;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: handshakes seen at the falling edge complete on the following rising edge.
  always @(negedge clk) begin
    if (rst) begin
      sbQ.delete();
      wrK = 0;
      prevHeld = 1'b0;
      framesOut = 0;
    end else begin
      if (prevHeld) begin
        checkOutput("holdValid", 32'(out_valid), 32'd1);
        checkOutput("holdR", 32'(data_out_r), 32'(heldR));
        checkOutput("holdI", 32'(data_out_i), 32'(heldI));
        checkOutput("holdLast", 32'(out_last), 32'(heldLast));
      end
      if (in_valid && in_ready) begin
        inAccepted++;
        frameR[wrK] = data_in_r;
        frameI[wrK] = data_in_i;
        wrK++;
        if (wrK == N) begin
          for (int n = 0; n < N; n++) begin
            sbQ.push_back('{r: frameR[revIdx(n)], i: frameI[revIdx(n)], last: (n == N - 1)});
          end
          wrK = 0;
        end
      end
      if (out_valid && out_ready) begin
        if (sbQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpectedOutput: got r=%0h with empty scoreboard at cycle %0d", data_out_r, cycle);
        end else begin
          expS = sbQ.pop_front();
          checkOutput("outR", 32'(data_out_r), 32'(expS.r));
          checkOutput("outI", 32'(data_out_i), 32'(expS.i));
          checkOutput("outLast", 32'(out_last), 32'(expS.last));
          if (expS.last) framesOut++;
        end
        outCycle.push_back(cycle);
        outCount++;
      end
      prevHeld = out_valid && !out_ready;
      heldR    = data_out_r;
      heldI    = data_out_i;
      heldLast = out_last;
    end
  end

  task automatic applyStimulus(input logic [DW-1:0] r, input logic [DW-1:0] i, output int stalls);
    in_valid  = 1'b1;
    data_in_r = r;
    data_in_i = i;
    stalls    = 0;
    @(negedge clk);
    while (!in_ready && stalls < 200) begin
      stalls++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL inputTimeout: in_ready got 0 expected 1 within 200 cycles");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic runOrderedFrame();
    int st;
    int ordTbl[16];
    ordTbl = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
    for (int k = 0; k < N; k++) applyStimulus(16'(k), 16'(-k), st);
    in_valid = 1'b0;
    checkOutput("latencyLow", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    for (int n = 0; n < N; n++) begin
      checkOutput("orderValid", 32'(out_valid), 32'd1);
      checkOutput("orderR", 32'(data_out_r), 32'(ordTbl[n]));
      checkOutput("orderLast", 32'(out_last), 32'(n == N - 1));
      @(posedge clk);
      #1;
    end
    checkOutput("validFalls", 32'(out_valid), 32'd0);
  endtask

  initial begin
    int st;
    int stallSum;
    int ob;
    int ib;
    rst = 1'b1;
    in_valid = 1'b0;
    data_in_r = '0;
    data_in_i = '0;
    @(posedge clk);
    #1;
    doReset();

    checkOutput("rstInReady", 32'(in_ready), 32'd1);
    checkOutput("rstOutValid", 32'(out_valid), 32'd0);
    checkOutput("rstOutLast", 32'(out_last), 32'd0);
    checkOutput("rstDataR", 32'(data_out_r), 32'd0);
    checkOutput("rstDataI", 32'(data_out_i), 32'd0);

    $display("[TB] single ordered frame");
    runOrderedFrame();

    $display("[TB] four back-to-back frames");
    ob = outCount;
    stallSum = 0;
    for (int k = 0; k < 4 * N; k++) begin
      applyStimulus(16'($urandom), 16'($urandom), st);
      stallSum += st;
    end
    in_valid = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    checkOutput("streamStalls", 32'(stallSum), 32'd0);
    checkOutput("streamCount", 32'(outCount - ob), 32'd64);
    if (outCount - ob == 64) begin
      checkOutput("streamNoGap", 32'(outCycle[ob + 63] - outCycle[ob]), 32'd63);
    end

    $display("[TB] output backpressure");
    ob = outCount;
    ib = inAccepted;
    readyMode = 1;
    fork
      begin
        for (int k = 0; k < 3 * N; k++) applyStimulus(16'($urandom), 16'($urandom), st);
        in_valid = 1'b0;
      end
      begin
        repeat (40) @(posedge clk);
        #1;
        checkOutput("stallAccepts", 32'(inAccepted - ib), 32'd32);
        checkOutput("stallInReady", 32'(in_ready), 32'd0);
        checkOutput("stallOutValid", 32'(out_valid), 32'd1);
        readyMode = 0;
      end
    join
    repeat (60) @(posedge clk);
    #1;
    checkOutput("releaseCount", 32'(outCount - ob), 32'd48);
    checkOutput("releaseDrained", 32'(sbQ.size()), 32'd0);

    $display("[TB] random backpressure, ten frames");
    ob = outCount;
    readyMode = 2;
    for (int k = 0; k < 10 * N; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      applyStimulus(16'($urandom), 16'($urandom), st);
    end
    in_valid = 1'b0;
    readyMode = 0;
    repeat (60) @(posedge clk);
    #1;
    checkOutput("randomCount", 32'(outCount - ob), 32'd160);
    checkOutput("randomDrained", 32'(sbQ.size()), 32'd0);

    $display("[TB] reset mid-frame");
    for (int k = 0; k < 7; k++) applyStimulus(16'($urandom), 16'($urandom), st);
    in_valid = 1'b0;
    doReset();
    checkOutput("midRstOutValid", 32'(out_valid), 32'd0);
    checkOutput("midRstInReady", 32'(in_ready), 32'd1);
    runOrderedFrame();
    repeat (5) @(posedge clk);
    #1;
    checkOutput("finalDrained", 32'(sbQ.size()), 32'd0);
`ifdef NATURAL_ORDER_BUFFER_FRAME_CNT_EN
    checkOutput("frameCount", 32'(frame_count), 32'(framesOut % 256));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/natural_order_buffer.md
NATURAL_ORDER_BUFFER -- requirements
Module: natural_order_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, width of each real/imag fixed-point component.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, with N = 2**ADDR_WIDTH points per frame.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  system clock, all state on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 in_valid  input  1  input sample present.
REQ-007 in_ready  output  1  block accepts input this cycle.
REQ-008 data_in_r  input  DATA_WIDTH  real part, arriving in bit-reversed index order.
REQ-009 data_in_i  input  DATA_WIDTH  imaginary part, arriving in bit-reversed index order.
REQ-010 out_valid  output  1  output sample present.
REQ-011 out_ready  input  1  downstream accepts output.
REQ-012 data_out_r  output  DATA_WIDTH  real part, natural index order.
REQ-013 data_out_i  output  DATA_WIDTH  imaginary part, natural index order.
REQ-014 out_last  output  1  marks sample n = N-1 of each output frame.

Function
REQ-015 SHALL hold two N-entry complex banks (ping-pong), register-array storage, no memory reset.
REQ-016 Transfer occurs on a side when valid and ready are both high at the clock edge.
REQ-017 Write side: k-th accepted sample of a frame (k = 0..N-1) SHALL be stored at address bit-reverse(k) of the current write bank.
REQ-018 in_ready SHALL equal NOT full-flag of the current write bank; combinational from state only, never from in_valid.
REQ-019 On acceptance of k = N-1, SHALL set that bank's full flag, toggle write bank, reset write count to 0.
REQ-020 Read side: SHALL load output registers from address n (n = 0..N-1, natural) of the read bank when that bank is full and (out_valid low or out_ready high).
REQ-021 Loading n = N-1 SHALL assert out_last with that sample, clear that bank's full flag, toggle read bank, reset read count.
REQ-022 While out_valid high and out_ready low, data_out_r, data_out_i, out_last SHALL hold stable.
REQ-023 out_valid SHALL fall after an accepted transfer when no further load occurs that cycle.
REQ-024 Latency: out_valid SHALL rise on the first rising edge after the edge accepting a frame's N-th input.
REQ-025 Throughput: with in_valid and out_ready held high, SHALL sustain one sample per clock in and out indefinitely after the first frame, no bubbles.
REQ-026 Simultaneous full-set on one bank and full-clear on the other in the same cycle SHALL both take effect.
REQ-027 Both banks full: in_ready low; input stalls without loss until the read side frees a bank.
REQ-028 Counters SHALL wrap modulo N; no arithmetic on data, values pass bit-exact.

Reset
REQ-029 On rst: in_ready 1 after reset, out_valid 0, out_last 0, data_out_r/data_out_i 0, both full flags 0, write/read bank 0, counts 0.
REQ-030 Reset mid-frame SHALL discard partial input and pending output frames; first post-reset sample is k = 0.
REQ-031 rst SHALL take priority over all simultaneous transfers.

Configuration
REQ-032 Macro NATURAL_ORDER_BUFFER_FRAME_CNT_EN, when defined, SHALL add output port frame_count (8 bits), reset 0, incremented modulo 256 on each accepted transfer with out_last high.
REQ-033 Without NATURAL_ORDER_BUFFER_FRAME_CNT_EN, frame_count port and its logic SHALL be absent; all other behaviour identical.

Verification (N = 16, DATA_WIDTH = 16)
REQ-034 Reset then one frame, input k carries r = k, i = -k, out_ready high -> outputs r = 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15, out_last on the 16th, out_valid rises one edge after the 16th input.
REQ-035 Continuous 4 frames, in_valid and out_ready always high -> 64 outputs with no gap, in_ready never low.
REQ-036 out_ready low for 40 cycles while input streams -> in_ready falls after 32 accepts, output held stable; release -> all 48 samples delivered in order, none lost.
REQ-037 Random out_ready toggling, 10 frames -> output sequence matches reference bit-reverse model exactly.
REQ-038 rst asserted after 7 inputs of a frame -> out_valid 0; next 16 inputs form a clean frame producing REQ-034 ordering.
REQ-039 With NATURAL_ORDER_BUFFER_FRAME_CNT_EN, 3 frames -> frame_count = 3; after 256 frames wraps to 0.
